phase_seq_arbiter: RTL and testbench

Shares one timed two-phase sequencer (IDLE -> S1 -> S2 -> IDLE) among NREQ requesters. Round-robin arbitration picks one requester per job. The block then times phase S1 for P1 cycles and phase S2 for P2 cycles, and reports completion or abort to that requester. It sits between the requesting client logic and the phase-driven datapath, which consumes phase/gnt.

---
 rtl/phase_seq_pkg.sv | 11 +
 rtl/rr_pick.sv | 41 ++++
 rtl/phase_seq_arbiter.sv | 140 ++++++++++++++
 tb/tb_phase_seq_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer arbiter.
//   phase_e : phase encoding driven on the phase output (11 is never used)
package phase_seq_pkg;

   typedef enum logic [1:0] {
      PH_IDLE = 2'b00,
      PH_S1   = 2'b01,
      PH_S2   = 2'b10
   } phase_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   last_id : index of the most recent winner; search starts just above it
//   winner  : first set request at last_id+1, last_id+2, ... (mod NREQ)
//   valid   : at least one request is set
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic [IDW-1:0]  winner,
   output logic            valid
);

   logic           hi_found;
   logic           lo_found;
   logic [IDW-1:0] hi_idx;
   logic [IDW-1:0] lo_idx;

   // Lowest set index above last_id wins; otherwise wrap to the lowest set index.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = IDW'(i);
         end
         if (req[i] && (IDW'(i) > last_id) && !hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDW'(i);
         end
      end
      valid  = lo_found;
      winner = hi_found ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/phase_seq_arbiter.sv
// Shares one timed two-phase sequencer (IDLE -> S1 -> S2 -> IDLE) among
// NREQ requesters with round-robin arbitration.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req             : level requests, held until done/abort
//   cfg_p1_len/p2   : phase lengths in cycles, sampled at grant (0 acts as 1)
//   gnt, gnt_id     : registered one-hot grant and its index
//   phase, busy     : current phase and phase != IDLE
//   done            : one-cycle pulse to the granted requester on completion
//   abort           : one-cycle pulse when the granted requester drops req
module phase_seq_arbiter
   import phase_seq_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CW   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [CW-1:0]   cfg_p1_len,
   input  logic [CW-1:0]   cfg_p2_len,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic [1:0]      phase,
   output logic            busy,
   output logic [NREQ-1:0] done,
   output logic            abort
);

   phase_e          phase_q, phase_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic [IDW-1:0]  last_id_q, last_id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   p1_q, p1_d;
   logic [CW-1:0]   p2_q, p2_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            abort_q, abort_d;

   logic [IDW-1:0]  win_id;
   logic            win_valid;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req     (req),
      .last_id (last_id_q),
      .winner  (win_id),
      .valid   (win_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= PH_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_id_q <= IDW'(NREQ - 1);
         cnt_q     <= '0;
         p1_q      <= CW'(1);
         p2_q      <= CW'(1);
         done_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_id_q <= last_id_d;
         cnt_q     <= cnt_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   always_comb begin
      phase_d   = phase_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_id_d = last_id_q;
      cnt_d     = cnt_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      done_d    = '0;
      abort_d   = 1'b0;

      case (phase_q)
         PH_IDLE: begin
            if (win_valid) begin
               phase_d   = PH_S1;
               gnt_d     = NREQ'(1) << win_id;
               gnt_id_d  = win_id;
               last_id_d = win_id;
               cnt_d     = '0;
               p1_d      = (cfg_p1_len == '0) ? CW'(1) : cfg_p1_len;
               p2_d      = (cfg_p2_len == '0) ? CW'(1) : cfg_p2_len;
            end
         end
         PH_S1, PH_S2: begin
            // gnt_q is one-hot on gnt_id, so masking req tests req[gnt_id].
            if ((req & gnt_q) == '0) begin
               phase_d = PH_IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               abort_d = 1'b1;
            end else if (phase_q == PH_S1) begin
               if (cnt_q == p1_q - CW'(1)) begin
                  phase_d = PH_S2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               if (cnt_q == p2_q - CW'(1)) begin
                  phase_d = PH_IDLE;
                  gnt_d   = '0;
                  cnt_d   = '0;
                  done_d  = gnt_q;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            phase_d = PH_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign phase  = phase_q;
   assign busy   = (phase_q != PH_IDLE);
   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign done   = done_q;
   assign abort  = abort_q;

endmodule

// File: tb/tb_phase_seq_arbiter.sv
// Scoreboard bench for phase_seq_arbiter: stimulus pushes the expected job
// record; a negedge monitor measures each job and compares on done/abort.
module tb_phase_seq_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CW   = 4;

   logic            clk;
   logic            rst_n;
   logic [NREQ-1:0] req;
   logic [CW-1:0]   cfg_p1_len;
   logic [CW-1:0]   cfg_p2_len;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic [1:0]      phase;
   logic            busy;
   logic [NREQ-1:0] done;
   logic            abort;

   phase_seq_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW),
      .CW   (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .cfg_p1_len (cfg_p1_len),
      .cfg_p2_len (cfg_p2_len),
      .gnt        (gnt),
      .gnt_id     (gnt_id),
      .phase      (phase),
      .busy       (busy),
      .done       (done),
      .abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_abort;
      int id;
      int s1;
      int s2;
      int gap;   // idle cycles since previous job end; -1 = don't care
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit is_abort, input int id, input int s1,
                       input int s2, input int gap);
      exp_t e;
      e.is_abort = is_abort;
      e.id       = id;
      e.s1       = s1;
      e.s2       = s2;
      e.gap      = gap;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_phase"},  int'(phase),  0);
      check({tag, "_gnt"},    int'(gnt),    0);
      check({tag, "_gnt_id"}, int'(gnt_id), 0);
      check({tag, "_busy"},   int'(busy),   0);
      check({tag, "_done"},   int'(done),   0);
      check({tag, "_abort"},  int'(abort),  0);
   endtask

   task automatic wait_event(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done != '0 || abort) && n < budget);
      if (!(done != '0 || abort)) begin
         n_err++;
         $display("FAIL event_timeout: no done/abort within %0d cycles at %0t", budget, $time);
      end
   endtask

   task automatic wait_busy(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < budget);
      if (!busy) begin
         n_err++;
         $display("FAIL busy_timeout: no grant within %0d cycles at %0t", budget, $time);
      end
   endtask

   // Monitor
   bit   in_job = 1'b0;
   int   cur_id, s1_cnt, s2_cnt, gap, idle_cnt = -1;
   bit   gnt_bad;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_job   = 1'b0;
         idle_cnt = -1;
      end else begin
         logic [NREQ-1:0] oh;
         oh = 4'b0001 << gnt_id;
         if (phase == 2'b01 && !in_job) begin
            in_job  = 1'b1;
            cur_id  = int'(gnt_id);
            s1_cnt  = 0;
            s2_cnt  = 0;
            gap     = idle_cnt;
            gnt_bad = 1'b0;
         end
         if (phase == 2'b01) s1_cnt++;
         if (phase == 2'b10) s2_cnt++;
         if (phase == 2'b11) gnt_bad = 1'b1;
         if (phase != 2'b00 && (gnt != oh || !busy || int'(gnt_id) != cur_id)) gnt_bad = 1'b1;
         if (phase == 2'b00 && (gnt != '0 || busy)) gnt_bad = 1'b1;
         if (phase == 2'b00) begin
            if (done != '0 || abort) begin
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_event: done=%b abort=%b at %0t", done, abort, $time);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("abort_flag", int'(abort), int'(e.is_abort));
                  check("done_vec", int'(done), e.is_abort ? 0 : (1 << e.id));
                  check("grant_id", cur_id, e.id);
                  check("s1_len", s1_cnt, e.s1);
                  check("s2_len", s2_cnt, e.s2);
                  if (e.gap >= 0) check("idle_gap", gap, e.gap);
                  check("gnt_consistency", int'(gnt_bad), 0);
               end
               in_job   = 1'b0;
               idle_cnt = 1;
            end else if (idle_cnt >= 0) begin
               idle_cnt++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s2_seen;
      rst_n      = 1'b0;
      req        = '0;
      cfg_p1_len = '0;
      cfg_p2_len = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");

      // Single job 5/7, grant latency one cycle
      cfg_p1_len = 4'd5;
      cfg_p2_len = 4'd7;
      push(1'b0, 0, 5, 7, -1);
      req = 4'b0001;
      @(negedge clk);
      check("grant_latency_phase", int'(phase), 1);
      check("grant_latency_gnt", int'(gnt), 1);
      wait_event(50);
      req = '0;

      // Round robin from reset: 0,1,2,3,0
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cfg_p1_len = 4'd1;
      cfg_p2_len = 4'd1;
      push(1'b0, 0, 1, 1, -1);
      push(1'b0, 1, 1, 1, 1);
      push(1'b0, 2, 1, 1, 1);
      push(1'b0, 3, 1, 1, 1);
      push(1'b0, 0, 1, 1, 1);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) wait_event(20);
      req = '0;

      // Zero lengths behave as 1/1; last winner 0 -> requester 2 next
      @(negedge clk);
      cfg_p1_len = 4'd0;
      cfg_p2_len = 4'd0;
      push(1'b0, 2, 1, 1, -1);
      req = 4'b0100;
      wait_event(20);
      req = '0;

      // Abort on S2 cycle 3; then 3 wins over 0, config change mid-job ignored
      @(negedge clk);
      cfg_p1_len = 4'd5;
      cfg_p2_len = 4'd7;
      push(1'b1, 2, 5, 3, -1);
      push(1'b0, 3, 2, 3, 1);
      push(1'b0, 0, 2, 3, 1);
      req = 4'b0100;
      wait_busy(10);
      req = 4'b1101;
      s2_seen = 0;
      for (int n = 0; n < 30 && s2_seen < 3; n++) begin
         if (n > 0) @(negedge clk);
         if (phase == 2'b10) s2_seen++;
      end
      req        = 4'b1001;
      cfg_p1_len = 4'd2;
      cfg_p2_len = 4'd3;
      wait_event(20);
      wait_event(20);
      req = 4'b0001;
      wait_event(20);
      req = '0;

      // Max length with config change after grant
      @(negedge clk);
      cfg_p1_len = 4'd15;
      cfg_p2_len = 4'd15;
      push(1'b0, 1, 15, 15, -1);
      req = 4'b0010;
      wait_busy(10);
      cfg_p1_len = 4'd2;
      cfg_p2_len = 4'd2;
      wait_event(100);
      req = '0;

      // Reset mid-S1; after release requester 0 wins over 1
      @(negedge clk);
      cfg_p1_len = 4'd3;
      cfg_p2_len = 4'd3;
      req = 4'b0011;
      wait_busy(10);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midjob_reset");
      push(1'b0, 0, 3, 3, -1);
      push(1'b0, 1, 3, 3, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_event(30);
      req = 4'b0010;
      wait_event(30);
      req = '0;

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
